// File: rtl/output_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : output_control                                             |
// | Description : Output-side I/O control for a basic accumulator computer.  |
// |               Holds the output register OUTR and output flag FGO,        |
// |               serialises OUTR to a printer as an 8N1 frame (start bit,   |
// |               8 data bits LSB first, stop bit), and owns the interrupt   |
// |               enable, the SKO skip request and the interrupt request.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters                                                               |
// |   CLKS_PER_BIT : clocks per serial bit (2..255)                          |
// | Ports                                                                    |
// |   clk    in   : clock, all state changes on the rising edge              |
// |   rst_n  in   : asynchronous active-low reset                            |
// |   p      in   : I/O instruction execute strobe (D7 & I & T3)             |
// |   b10    in   : OUT instruction bit                                      |
// |   b8     in   : SKO instruction bit                                      |
// |   b7     in   : ION instruction bit                                      |
// |   b6     in   : IOF instruction bit                                      |
// |   r      in   : interrupt-cycle flag                                     |
// |   t2     in   : timing signal T2                                         |
// |   fgi    in   : input flag from the input control block                  |
// |   ac_in  in   : AC[7:0]                                                  |
// |   outr   out  : output register                                          |
// |   fgo    out  : output flag, 1 = printer ready for a character           |
// |   ien    out  : interrupt enable                                         |
// |   skip   out  : one-cycle PC increment request                           |
// |   irq    out  : interrupt request                                        |
// |   tx     out  : serial line to the printer, idle high                    |
// +--------------------------------------------------------------------------+
module output_control #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       p,
  input  logic       b10,
  input  logic       b8,
  input  logic       b7,
  input  logic       b6,
  input  logic       r,
  input  logic       t2,
  input  logic       fgi,
  input  logic [7:0] ac_in,
  output logic [7:0] outr,
  output logic       fgo,
  output logic       ien,
  output logic       skip,
  output logic       irq,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       c_idx_last = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  tx_state_t        r_state;
  tx_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_next;
  logic [2:0]       w_bit_idx_inc;
  logic             r_tx;
  logic             w_tx_next;
  logic             w_frame_done;
  logic             w_bit_end;

  logic [7:0]       r_outr;
  logic             r_fgo;
  logic             r_ien;
  logic             r_skip;
  logic             r_irq;

  logic             w_out_go;
  logic             w_sko;
  logic             w_ion;
  logic             w_iof;
  logic             w_int_entry;

  // Instruction decode. An OUT is only accepted while the printer is ready;
  // fgo=1 already implies IDLE, the state term keeps the FSM self-consistent.
  assign w_out_go    = p & b10 & r_fgo & (r_state == ST_IDLE);
  assign w_sko       = p & b8;
  assign w_ion       = p & b7;
  assign w_iof       = p & b6;
  assign w_int_entry = r & t2;

  assign w_bit_end     = (r_cnt == c_cnt_last);
  assign w_bit_idx_inc = r_bit_idx + 3'd1;

  // ------------------------------------------------------------------------
  // Transmitter state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_bit_idx <= w_bit_idx_next;
      r_tx      <= w_tx_next;
    end
  end

  // ------------------------------------------------------------------------
  // Transmitter next-state logic. The line value is computed for the state
  // being entered so that tx comes straight from a flop and never glitches.
  // ------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_bit_idx_next = r_bit_idx;
    w_tx_next      = r_tx;
    w_frame_done   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_tx_next      = 1'b1;
        w_cnt_next     = '0;
        w_bit_idx_next = 3'd0;
        if (w_out_go) begin
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end
      end

      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_cnt_next     = '0;
          w_bit_idx_next = 3'd0;
          w_tx_next      = r_outr[0];
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (w_bit_end) begin
          w_cnt_next = '0;
          if (r_bit_idx == c_idx_last) begin
            w_state_next = ST_STOP;
            w_tx_next    = 1'b1;
          end else begin
            w_bit_idx_next = w_bit_idx_inc;
            w_tx_next      = r_outr[w_bit_idx_inc];
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        w_tx_next = 1'b1;
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_frame_done = 1'b1;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_next   = ST_IDLE;
        w_cnt_next     = '0;
        w_bit_idx_next = 3'd0;
        w_tx_next      = 1'b1;
      end
    endcase
  end

  // ------------------------------------------------------------------------
  // Output register and output flag. fgo drops on the OUT edge and rises on
  // the edge that ends the last stop-bit cycle.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outr <= 8'h00;
      r_fgo  <= 1'b1;
    end else begin
      if (w_out_go) begin
        r_outr <= ac_in;
        r_fgo  <= 1'b0;
      end else if (w_frame_done) begin
        r_fgo <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Interrupt enable, skip and interrupt request. Clearing sources (IOF and
  // interrupt-cycle entry) take priority over ION.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ien  <= 1'b0;
      r_skip <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      if (w_int_entry || w_iof) begin
        r_ien <= 1'b0;
      end else if (w_ion) begin
        r_ien <= 1'b1;
      end
      r_skip <= w_sko & r_fgo;
      r_irq  <= r_ien & (fgi | r_fgo) & ~r;
    end
  end

  assign outr = r_outr;
  assign fgo  = r_fgo;
  assign ien  = r_ien;
  assign skip = r_skip;
  assign irq  = r_irq;
  assign tx   = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_output_control.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_output_control                                          |
// | Description : Self-checking bench for output_control. A frame-level      |
// |               reference model predicts every output each cycle; directed |
// |               sequences pin the model with literal expectations, then    |
// |               randomized traffic runs against the model.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_output_control;

  localparam int CLKS_PER_BIT = 4;
  localparam int FRAME_CLKS   = 10 * CLKS_PER_BIT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       p = 1'b0, b10 = 1'b0, b8 = 1'b0, b7 = 1'b0, b6 = 1'b0;
  logic       r = 1'b0, t2 = 1'b0, fgi = 1'b0;
  logic [7:0] ac_in = 8'h00;
  logic [7:0] outr;
  logic       fgo, ien, skip, irq, tx;

  int checks = 0;
  int errors = 0;

  output_control #(.CLKS_PER_BIT(CLKS_PER_BIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .p     (p),
    .b10   (b10),
    .b8    (b8),
    .b7    (b7),
    .b6    (b6),
    .r     (r),
    .t2    (t2),
    .fgi   (fgi),
    .ac_in (ac_in),
    .outr  (outr),
    .fgo   (fgo),
    .ien   (ien),
    .skip  (skip),
    .irq   (irq),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------------
  // Reference model: a frame is just a position counter into the 10-bit
  // pattern {stop, data, start}; the printer is ready when no frame runs.
  // ------------------------------------------------------------------------
  int         m_pos  = -1;
  logic [7:0] m_outr = 8'h00;
  logic       m_ien  = 1'b0;
  logic       m_skip = 1'b0;
  logic       m_irq  = 1'b0;

  function automatic logic m_fgo();
    return (m_pos < 0);
  endfunction

  function automatic logic m_tx();
    logic [9:0] frame;
    frame = {1'b1, m_outr, 1'b0};
    if (m_pos < 0) return 1'b1;
    return frame[m_pos / CLKS_PER_BIT];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic n_ien, n_skip, n_irq, accept;
    if (!rst_n) begin
      m_pos  = -1;
      m_outr = 8'h00;
      m_ien  = 1'b0;
      m_skip = 1'b0;
      m_irq  = 1'b0;
    end else begin
      accept = p & b10 & m_fgo();
      n_skip = p & b8 & m_fgo();
      n_irq  = m_ien & (fgi | m_fgo()) & ~r;
      if ((r & t2) | (p & b6)) n_ien = 1'b0;
      else if (p & b7)         n_ien = 1'b1;
      else                     n_ien = m_ien;
      if (accept) begin
        m_outr = ac_in;
        m_pos  = 0;
      end else if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FRAME_CLKS) m_pos = -1;
      end
      m_ien  = n_ien;
      m_skip = n_skip;
      m_irq  = n_irq;
    end
  end

  // One compare process checks every output against the model each cycle.
  always @(negedge clk) begin
    chk("model_outr", {24'd0, outr}, {24'd0, m_outr});
    chk("model_fgo",  {31'd0, fgo},  {31'd0, m_fgo()});
    chk("model_ien",  {31'd0, ien},  {31'd0, m_ien});
    chk("model_skip", {31'd0, skip}, {31'd0, m_skip});
    chk("model_irq",  {31'd0, irq},  {31'd0, m_irq});
    chk("model_tx",   {31'd0, tx},   {31'd0, m_tx()});
  end

  task automatic clear_ctl();
    p = 1'b0; b10 = 1'b0; b8 = 1'b0; b7 = 1'b0; b6 = 1'b0;
    r = 1'b0; t2 = 1'b0;
  endtask

  initial begin
    logic [9:0] seq_a5;
    logic [9:0] seq_ff;
    seq_a5 = 10'b1101001010;  // position 0 (start) is the LSB
    seq_ff = 10'b1111111110;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outr", {24'd0, outr}, 32'h00);
    chk("rst_fgo",  {31'd0, fgo},  32'd1);
    chk("rst_ien",  {31'd0, ien},  32'd0);
    chk("rst_skip", {31'd0, skip}, 32'd0);
    chk("rst_irq",  {31'd0, irq},  32'd0);
    chk("rst_tx",   {31'd0, tx},   32'd1);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // OUT 0xA5: full frame, with a rejected OUT and a mid-frame SKO inside
    p = 1'b1; b10 = 1'b1; ac_in = 8'hA5;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      @(negedge clk);
      clear_ctl();
      chk("a5_tx",   {31'd0, tx},  {31'd0, seq_a5[k / CLKS_PER_BIT]});
      chk("a5_fgo",  {31'd0, fgo}, 32'd0);
      chk("a5_outr", {24'd0, outr}, 32'hA5);
      if (k == 5) begin p = 1'b1; b10 = 1'b1; ac_in = 8'h3C; end
      if (k == 9) begin p = 1'b1; b8 = 1'b1; end
      if (k == 10) chk("sko_midframe", {31'd0, skip}, 32'd0);
    end
    @(negedge clk);
    chk("a5_fgo_done", {31'd0, fgo},  32'd1);
    chk("a5_tx_idle",  {31'd0, tx},   32'd1);
    chk("a5_outr_end", {24'd0, outr}, 32'hA5);

    // SKO while ready
    p = 1'b1; b8 = 1'b1;
    @(negedge clk);
    clear_ctl();
    chk("sko_skip_hi", {31'd0, skip}, 32'd1);
    @(negedge clk);
    chk("sko_skip_lo", {31'd0, skip}, 32'd0);

    // ION, then irq from fgi; interrupt-cycle entry; ION+IOF together
    p = 1'b1; b7 = 1'b1; fgi = 1'b1;
    @(negedge clk);
    clear_ctl();
    chk("ion_ien", {31'd0, ien}, 32'd1);
    @(negedge clk);
    chk("ion_irq", {31'd0, irq}, 32'd1);
    r = 1'b1; t2 = 1'b1;
    @(negedge clk);
    clear_ctl();
    chk("rt2_ien", {31'd0, ien}, 32'd0);
    chk("rt2_irq", {31'd0, irq}, 32'd0);
    p = 1'b1; b7 = 1'b1; b6 = 1'b1;
    @(negedge clk);
    clear_ctl();
    fgi = 1'b0;
    chk("ion_iof_ien", {31'd0, ien}, 32'd0);

    // Reset during data bit 3 of a frame, then a fresh frame of 0xFF
    p = 1'b1; b10 = 1'b1; ac_in = 8'h5A;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      clear_ctl();
    end
    chk("bit3_tx", {31'd0, tx}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_tx",   {31'd0, tx},   32'd1);
    chk("abort_fgo",  {31'd0, fgo},  32'd1);
    chk("abort_outr", {24'd0, outr}, 32'h00);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_tx", {31'd0, tx}, 32'd1);
    end
    p = 1'b1; b10 = 1'b1; ac_in = 8'hFF;
    for (int k = 0; k < FRAME_CLKS; k++) begin
      @(negedge clk);
      clear_ctl();
      chk("ff_tx",  {31'd0, tx},  {31'd0, seq_ff[k / CLKS_PER_BIT]});
      chk("ff_fgo", {31'd0, fgo}, 32'd0);
    end
    @(negedge clk);
    chk("ff_fgo_done", {31'd0, fgo}, 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      p     = ($urandom_range(0, 3) == 0);
      b10   = $urandom_range(0, 1) == 1;
      b8    = $urandom_range(0, 1) == 1;
      b7    = $urandom_range(0, 1) == 1;
      b6    = ($urandom_range(0, 3) == 0);
      r     = ($urandom_range(0, 7) == 0);
      t2    = $urandom_range(0, 1) == 1;
      fgi   = $urandom_range(0, 1) == 1;
      ac_in = 8'($urandom);
      #2 rst_n = ($urandom_range(0, 299) != 0);
    end
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/output_control.md
OUTPUT_CONTROL -- requirements
Module: output_control

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 4, giving clocks per serial bit (legal range 2..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port p, input, 1, I/O-instruction execute strobe (D7·I·T3), one cycle.
REQ-005 SHALL have ports b10, b8, b7, b6, input, 1 each: OUT, SKO, ION, IOF instruction bits, qualified by p.
REQ-006 SHALL have ports r, t2, input, 1 each: interrupt-cycle flag and timing signal T2.
REQ-007 SHALL have port fgi, input, 1, input flag from the input control block.
REQ-008 SHALL have port ac_in, input, 8, AC[7:0].
REQ-009 SHALL have port outr, output, 8, output register OUTR.
REQ-010 SHALL have port fgo, output, 1, output flag (1 = device ready for a character).
REQ-011 SHALL have port ien, output, 1, interrupt enable.
REQ-012 SHALL have port skip, output, 1, one-cycle PC-increment request.
REQ-013 SHALL have port irq, output, 1, interrupt request to set R.
REQ-014 SHALL have port tx, output, 1, serial line to the printer (idle high).

Function
REQ-015 OUT (p & b10 & fgo) SHALL load outr <= ac_in and clear fgo on the same edge.
REQ-016 OUT with fgo=0 SHALL be ignored: outr, fgo and the transmitter are unchanged.
REQ-017 Transmitter SHALL be an FSM with states IDLE, START, DATA, STOP.
REQ-018 IDLE SHALL drive tx=1 and move to START on the cycle after a successful OUT.
REQ-019 START SHALL drive tx=0 for CLKS_PER_BIT cycles.
REQ-020 DATA SHALL drive outr[0]..outr[7], LSB first, each bit for CLKS_PER_BIT cycles, using a 3-bit bit index and a bit-period counter.
REQ-021 STOP SHALL drive tx=1 for CLKS_PER_BIT cycles; on its last cycle fgo SHALL be set to 1 and the FSM returns to IDLE.
REQ-022 A frame SHALL be 10*CLKS_PER_BIT cycles from the first START cycle to fgo=1; tx SHALL be registered and glitch-free.
REQ-023 outr SHALL hold its value for the whole frame; a later OUT cannot occur mid-frame because fgo=0.
REQ-024 SKO (p & b8) SHALL assert skip for exactly the next cycle when fgo=1, and leave skip low when fgo=0.
REQ-025 ION (p & b7) SHALL set ien; IOF (p & b6) SHALL clear ien; if both are asserted, IOF wins.
REQ-026 r & t2 SHALL clear ien (interrupt-cycle entry) with priority over ION.
REQ-027 irq SHALL be registered as ien & (fgi | fgo) & ~r.
REQ-028 Multiple b bits asserted with p SHALL each act independently in the same cycle.
REQ-029 b bits without p SHALL have no effect.

Reset
REQ-030 rst_n=0 SHALL immediately force: outr=0, fgo=1, ien=0, skip=0, irq=0, tx=1, FSM=IDLE, counters=0.
REQ-031 Reset mid-frame SHALL abort the frame with no partial bits after release; the next OUT starts a fresh frame.

Verification
REQ-032 Reset, then OUT with ac_in=8'hA5 -> outr=A5, fgo=0; tx sequence 0,1,0,1,0,0,1,0,1,1 (4 clocks each); fgo=1 at 40 cycles.
REQ-033 OUT with ac_in=8'h3C during the frame of 8'hA5 -> ignored; outr stays A5; frame unchanged.
REQ-034 SKO with fgo=1 -> skip high for exactly 1 cycle; SKO mid-frame -> skip stays 0.
REQ-035 ION then fgi=1 -> irq=1 on the next edge; r=1,t2=1 -> ien=0, irq=0; ION+IOF together -> ien=0.
REQ-036 Assert rst_n=0 at bit 3 of a frame -> tx=1, fgo=1 immediately; after release, OUT 8'hFF -> full valid frame.
